ddr_req_arbiter: RTL and testbench

Two-requester arbiter that shares one single-beat AXI-style DDR controller port (AW/W/AR/R channels, no B channel) between two on-chip masters. Each requester issues one read or write command at a time through a simple valid/ready command interface and gets a one-cycle response pulse on completion. The block sits between the requesters and the DDR controller. It issues DDR commands only when `ddr_ready` is high.

---
 rtl/ddr_req_arbiter_if.sv | 48 ++++
 rtl/ddr_req_arbiter.sv | 141 ++++++++++++++
 tb/tb_ddr_req_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_req_arbiter_if.sv
// Bundles the two-requester command/response bus and the single-beat DDR
// (AW/W/AR/R) bus seen by ddr_req_arbiter. slave = arbiter side, master = requesters/DDR side.
interface ddr_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]              cmd_valid;
  logic [1:0]              cmd_ready;
  logic [1:0]              cmd_we;
  logic [2*ADDR_W-1:0]     cmd_addr;
  logic [2*DATA_W-1:0]     cmd_wdata;
  logic [2*DATA_W/8-1:0]   cmd_wstrb;
  logic [1:0]              rsp_valid;
  logic [DATA_W-1:0]       rsp_rdata;

  logic [ADDR_W-1:0]       awaddr;
  logic                    awvalid;
  logic [7:0]              awlen;
  logic                    awready;
  logic [DATA_W-1:0]       wdata;
  logic [DATA_W/8-1:0]     wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [ADDR_W-1:0]       araddr;
  logic                    arvalid;
  logic [7:0]              arlen;
  logic                    arready;
  logic [DATA_W-1:0]       rdata;
  logic                    rvalid;
  logic                    rready;
  logic                    ddr_ready;

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb,
    input  awready, wready, arready, rdata, rvalid, ddr_ready,
    output cmd_ready, rsp_valid, rsp_rdata,
    output awaddr, awvalid, awlen, wdata, wstrb, wvalid,
    output araddr, arvalid, arlen, rready
  );

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb,
    output awready, wready, arready, rdata, rvalid, ddr_ready,
    input  cmd_ready, rsp_valid, rsp_rdata,
    input  awaddr, awvalid, awlen, wdata, wstrb, wvalid,
    input  araddr, arvalid, arlen, rready
  );
endinterface

// File: rtl/ddr_req_arbiter.sv
// Two-requester arbiter sharing one single-beat DDR port, one command in flight.
// Define DDR_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module ddr_req_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst,
  ddr_req_arbiter_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ_ADDR,
    S_READ_DATA,
    S_DONE
  } state_t;

  state_t              r_state;
  logic                r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_arvalid;
  logic                r_rready;
  logic [1:0]          r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;

  logic                w_grant_en;
  logic                w_gnt_idx;
  logic                w_gnt_we;
  logic [ADDR_W-1:0]   w_gnt_addr;
  logic [DATA_W-1:0]   w_gnt_wdata;
  logic [STRB_W-1:0]   w_gnt_wstrb;
  logic                w_aw_done;
  logic                w_w_done;

`ifdef DDR_ARB_FIXED_PRIO_EN
  assign w_gnt_idx = ~bus.cmd_valid[0];
`else
  logic r_last;
  assign w_gnt_idx = (&bus.cmd_valid) ? ~r_last : bus.cmd_valid[1];
`endif

  assign w_grant_en  = (r_state == S_IDLE) && bus.ddr_ready && (|bus.cmd_valid);
  assign w_gnt_we    = bus.cmd_we[w_gnt_idx];
  assign w_gnt_addr  = w_gnt_idx ? bus.cmd_addr[2*ADDR_W-1:ADDR_W]   : bus.cmd_addr[ADDR_W-1:0];
  assign w_gnt_wdata = w_gnt_idx ? bus.cmd_wdata[2*DATA_W-1:DATA_W] : bus.cmd_wdata[DATA_W-1:0];
  assign w_gnt_wstrb = w_gnt_idx ? bus.cmd_wstrb[2*STRB_W-1:STRB_W] : bus.cmd_wstrb[STRB_W-1:0];

  // A write channel counts as finished if it already dropped or handshakes this edge.
  assign w_aw_done = ~r_awvalid | bus.awready;
  assign w_w_done  = ~r_wvalid  | bus.wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_rsp_rdata <= '0;
`ifndef DDR_ARB_FIXED_PRIO_EN
      r_last      <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_en) begin
            r_owner <= w_gnt_idx;
            r_addr  <= w_gnt_addr;
            r_wdata <= w_gnt_wdata;
            r_wstrb <= w_gnt_wstrb;
`ifndef DDR_ARB_FIXED_PRIO_EN
            r_last  <= w_gnt_idx;
`endif
            if (w_gnt_we) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WRITE;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_READ_ADDR;
            end
          end
        end
        S_WRITE: begin
          if (r_awvalid && bus.awready) r_awvalid <= 1'b0;
          if (r_wvalid && bus.wready)   r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
            r_state     <= S_DONE;
          end
        end
        S_READ_ADDR: begin
          if (bus.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_READ_DATA;
          end
        end
        S_READ_DATA: begin
          if (bus.rvalid) begin
            r_rsp_rdata <= bus.rdata;
            r_rready    <= 1'b0;
            r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_rsp_valid <= 2'b00;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = w_grant_en ? (w_gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.awaddr    = r_addr;
  assign bus.awvalid   = r_awvalid;
  assign bus.awlen     = 8'd0;
  assign bus.wdata     = r_wdata;
  assign bus.wstrb     = r_wstrb;
  assign bus.wvalid    = r_wvalid;
  assign bus.araddr    = r_addr;
  assign bus.arvalid   = r_arvalid;
  assign bus.arlen     = 8'd0;
  assign bus.rready    = r_rready;
endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Bench for ddr_req_arbiter: directed scenarios then random traffic, checked against
// a transaction-level model (round-robin rule, byte-strobed memory, channel handshake rules).
module tb_ddr_req_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  ddr_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  ddr_req_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic        mdl_last;
  logic [31:0] mdl_rdata;
  logic [31:0] mem [logic [31:0]];
  logic        p_we    [2];
  logic [31:0] p_addr  [2];
  logic [31:0] p_wdata [2];
  logic [3:0]  p_wstrb [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5a5a0f0f;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic rand_cmd(input int i);
    p_we[i]    = 1'($urandom_range(0, 1));
    p_addr[i]  = 32'h8f00_0000 | ($urandom_range(0, 3) << 2);
    p_wdata[i] = $urandom;
    p_wstrb[i] = 4'($urandom_range(1, 15));
  endtask

  task automatic drive_cmds(input logic [1:0] vmask);
    bus.cmd_valid = vmask;
    bus.cmd_we    = {p_we[1], p_we[0]};
    bus.cmd_addr  = {p_addr[1], p_addr[0]};
    bus.cmd_wdata = {p_wdata[1], p_wdata[0]};
    bus.cmd_wstrb = {p_wstrb[1], p_wstrb[0]};
  endtask

  // Holds ddr_ready low for idle_lo cycles, then raises it and expects the model's grant.
  task automatic grant(input logic [1:0] vmask, input int idle_lo, output int g, output int go);
    for (int i = 0; i < idle_lo; i++) begin
      @(negedge clk);
      drive_cmds(vmask);
      bus.ddr_ready = 1'b0;
      bus.rvalid = 1'($urandom_range(0, 1));
      bus.rdata  = $urandom;
      #1;
      chk("no_grant_ddr_low", bus.cmd_ready, 0);
      chk("axi_quiet_ddr_low", {bus.awvalid, bus.wvalid, bus.arvalid, bus.rready}, 0);
      chk("rdata_hold_idle", bus.rsp_rdata, mdl_rdata);
    end
    @(negedge clk);
    drive_cmds(vmask);
    bus.ddr_ready = 1'b1;
    bus.rvalid = 1'($urandom_range(0, 1));
    bus.rdata  = $urandom;
    #1;
`ifdef DDR_ARB_FIXED_PRIO_EN
    g = vmask[0] ? 0 : 1;
`else
    g = (vmask == 2'b11) ? (mdl_last ? 0 : 1) : (vmask[1] ? 1 : 0);
    mdl_last = g[0];
`endif
    chk("grant", bus.cmd_ready, (g == 1) ? 2'b10 : 2'b01);
    chk("grant_axi_quiet", {bus.awvalid, bus.wvalid, bus.arvalid, bus.rready}, 0);
    chk("grant_no_rsp", bus.rsp_valid, 0);
    chk("rdata_hold_grant", bus.rsp_rdata, mdl_rdata);
    go = (bus.cmd_ready == 2'b10) ? 1 : 0;
  endtask

  // Plays the DDR side for the granted command and checks every cycle up to the response.
  task automatic serve(input int g, input int aw_dly, input int w_dly, input int ar_dly,
                       input int r_dly, input bit spur);
    bit we, aw_done, w_done, ar_done, r_done, got;
    bit e_aw, e_w, e_ar, e_rr, e_rsp, real_r;
    int ar_hs, fin;
    logic [31:0] a;
    we = p_we[g]; a = p_addr[g];
    aw_done = 0; w_done = 0; ar_done = 0; r_done = 0; got = 0;
    ar_hs = 0; fin = 0;
    for (int t = 1; t <= 200 && !got; t++) begin
      @(negedge clk);
      e_aw  = we && !aw_done;
      e_w   = we && !w_done;
      e_ar  = !we && !ar_done;
      e_rr  = !we && ar_done && !r_done;
      e_rsp = (fin != 0) && (t == fin + 1);
      real_r = e_rr && (t >= ar_hs + r_dly);
      bus.ddr_ready = 1'($urandom_range(0, 1));
      bus.awready = (t > aw_dly);
      bus.wready  = (t > w_dly);
      bus.arready = (t > ar_dly);
      bus.rvalid  = real_r || (spur && !e_rr);
      bus.rdata   = real_r ? mem_rd(a) : $urandom;
      #1;
      chk("awvalid", bus.awvalid, e_aw);
      chk("wvalid", bus.wvalid, e_w);
      chk("arvalid", bus.arvalid, e_ar);
      chk("rready", bus.rready, e_rr);
      chk("rsp_valid", bus.rsp_valid, e_rsp ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00);
      chk("busy_no_grant", bus.cmd_ready, 0);
      chk("rsp_rdata", bus.rsp_rdata, mdl_rdata);
      if (e_aw) chk("awaddr", bus.awaddr, a);
      if (e_w)  chk("wdata_wstrb", {bus.wstrb, bus.wdata}, {p_wstrb[g], p_wdata[g]});
      if (e_ar) chk("araddr", bus.araddr, a);
      if (e_aw && bus.awready) aw_done = 1;
      if (e_w && bus.wready)   w_done = 1;
      if (we && aw_done && w_done && fin == 0) begin
        fin = t;
        mem[a] = merge(mem_rd(a), p_wdata[g], p_wstrb[g]);
      end
      if (e_ar && bus.arready) begin ar_done = 1; ar_hs = t; end
      if (real_r) begin
        r_done = 1; fin = t;
        mdl_rdata = mem_rd(a);
      end
      if (e_rsp) got = 1;
    end
    chk("rsp_seen", got, 1);
    chk("axlen_zero", {bus.awlen, bus.arlen}, 0);
    bus.rvalid = 1'b0;
  endtask

  initial begin
    int g, go, seen;
    int order [4];
    int exp_order [4];
    rst = 1'b1;
    bus.cmd_valid = '0; bus.cmd_we = '0; bus.cmd_addr = '0; bus.cmd_wdata = '0; bus.cmd_wstrb = '0;
    bus.awready = 0; bus.wready = 0; bus.arready = 0; bus.rdata = '0; bus.rvalid = 0;
    bus.ddr_ready = 0;
    mdl_last = 1'b1;
    mdl_rdata = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.rready, bus.rsp_valid, bus.cmd_ready}, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_cmd_latch", {bus.awaddr, bus.wdata, bus.wstrb}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Tie held off by ddr_ready, then requester 0 wins and writes with AW delayed 3 cycles.
    p_we[0] = 1; p_addr[0] = 32'h8f00f000; p_wdata[0] = 32'h87654321; p_wstrb[0] = 4'hf;
    p_we[1] = 0; p_addr[1] = 32'h8f00f000; p_wdata[1] = 32'h0;        p_wstrb[1] = 4'h0;
    grant(2'b11, 3, g, go);
    chk("first_tie_req0", go, 0);
    serve(g, 3, 0, 0, 1, 1);

    // Requester 1 reads it back with rvalid 5 cycles after AR.
    grant(2'b10, 0, g, go);
    serve(g, 0, 0, 0, 5, 1);
    chk("read_back", bus.rsp_rdata, 32'h87654321);

    // Both requesters valid across four commands.
`ifdef DDR_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++) begin
      rand_cmd(0); rand_cmd(1);
      grant(2'b11, 0, g, go);
      order[i] = go;
      serve(g, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(1, 3), 1);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("grant_order_%0d", i), order[i], exp_order[i]);

    // Reset while requester 0's read waits in the data phase.
    p_we[0] = 0; p_addr[0] = 32'h8f000004;
    grant(2'b01, 0, g, go);
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      bus.cmd_valid = 2'b00; bus.arready = 1'b1; bus.rvalid = 1'b0; bus.ddr_ready = 1'b1;
      #1;
      seen = bus.rready ? 1 : 0;
    end
    chk("reached_read_data", seen, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.rready, bus.rsp_valid}, 0);
    chk("async_rst_rdata", bus.rsp_rdata, 0);
    mdl_last = 1'b1;
    mdl_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    rand_cmd(0); rand_cmd(1);
    grant(2'b11, 0, g, go);
    chk("post_reset_gnt", go, 0);
    serve(g, 0, 0, 0, 1, 0);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      rand_cmd(0); rand_cmd(1);
      grant(2'($urandom_range(1, 3)), $urandom_range(0, 2), g, go);
      serve(g, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
